// File: rtl/float_divider_double_if.sv
// Operand/result handshake bundle for the double-precision divider.
// slave = divider side, master = producer/consumer side.
interface float_divider_double_if #(
  parameter int FLOAT_SIZE = 64
);
  logic [FLOAT_SIZE-1:0] a;
  logic [FLOAT_SIZE-1:0] b;
  logic                  in_valid;
  logic                  in_ready;
  logic [FLOAT_SIZE-1:0] out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overflow;
  logic                  underflow;
  logic                  inexact;
  logic                  zero;
  logic                  divide_by_zero;

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out, out_valid,
    output overflow, underflow, inexact,
    output zero, divide_by_zero
  );

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out, out_valid,
    input  overflow, underflow, inexact,
    input  zero, divide_by_zero
  );
endinterface

// File: rtl/float_divider_double.sv
// Iterative IEEE-754 double divider: restoring datapath,
// one quotient bit per cycle, truncating result.
module float_divider_double #(
  parameter int FLOAT_SIZE    = 64,
  parameter int EXPONENT_SIZE = 11,
  parameter int MANTISSA_SIZE = 52,
  parameter int BIAS          = 1023
) (
  input logic                   clk,
  input logic                   reset,
  float_divider_double_if.slave bus
);
  localparam int MW = MANTISSA_SIZE;
  localparam int EW = EXPONENT_SIZE;
  localparam int QW = MW + 2;
  localparam int RW = MW + 3;
  localparam logic [5:0] CNT_TOP = 6'(QW - 1);
  localparam logic signed [12:0] EMAX =
    13'((1 << EW) - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [FLOAT_SIZE-1:0] a_q, a_d;
  logic [FLOAT_SIZE-1:0] b_q, b_d;
  logic [FLOAT_SIZE-1:0] out_q, out_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic [5:0]            cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic inx_q, inx_d;
  logic zro_q, zro_d;
  logic dbz_q, dbz_d;

  logic          sgn;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] mb;
  logic          a_zero_i, b_zero_i;
  logic          a_zero_q, b_zero_q;

  assign sgn = a_q[FLOAT_SIZE-1] ^ b_q[FLOAT_SIZE-1];
  assign ea  = a_q[FLOAT_SIZE-2 -: EW];
  assign eb  = b_q[FLOAT_SIZE-2 -: EW];
  assign mb  = b_q[MW-1:0];

  assign a_zero_i = (bus.a[FLOAT_SIZE-2:0] == '0);
  assign b_zero_i = (bus.b[FLOAT_SIZE-2:0] == '0);
  assign a_zero_q = (a_q[FLOAT_SIZE-2:0] == '0);
  assign b_zero_q = (b_q[FLOAT_SIZE-2:0] == '0);

  logic [RW-1:0] dvs;
  logic          ge;
  logic [RW-1:0] rsub;

  assign dvs  = {3'b001, mb};
  assign ge   = (rem_q >= dvs);
  assign rsub = ge ? (rem_q - dvs) : rem_q;

  logic                 adj;
  logic [MW-1:0]        mant;
  logic signed [12:0]   exp_s;
  logic                 inx_n;

  // Quotient lies in [0.5, 2): top bit tells which half.
  assign adj   = ~quo_q[QW-1];
  assign mant  = quo_q[QW-1] ? quo_q[QW-2:1]
                             : quo_q[MW-1:0];
  assign exp_s = {2'b00, ea} - {2'b00, eb}
               + 13'(BIAS) - {12'd0, adj};
  assign inx_n = (rem_q != '0)
               | (quo_q[QW-1] & quo_q[0]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;
    zro_d   = zro_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          rem_d   = {3'b001, bus.a[MW-1:0]};
          cnt_d   = CNT_TOP;
          state_d = (a_zero_i | b_zero_i) ? NORM
                                          : DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = rsub << 1;
        quo_d = {quo_q[QW-2:0], ge};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == '0) state_d = NORM;
      end
      NORM: begin
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        inx_d   = 1'b0;
        zro_d   = 1'b0;
        dbz_d   = 1'b0;
        state_d = DONE;
        if (b_zero_q) begin
          dbz_d = 1'b1;
          out_d = {sgn, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero_q) begin
          zro_d = 1'b1;
          out_d = {sgn, {(FLOAT_SIZE-1){1'b0}}};
        end else begin
          inx_d = inx_n;
          if (exp_s >= EMAX) begin
            ovf_d = 1'b1;
            out_d = {sgn, {EW{1'b1}}, {MW{1'b0}}};
          end else if (exp_s <= 13'sd0) begin
            unf_d = 1'b1;
            zro_d = 1'b1;
            out_d = {sgn, {(FLOAT_SIZE-1){1'b0}}};
          end else begin
            out_d = {sgn, exp_s[EW-1:0], mant};
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
      zro_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
      zro_q   <= zro_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.out_valid      = (state_q == DONE);
  assign bus.out            = out_q;
  assign bus.overflow       = ovf_q;
  assign bus.underflow      = unf_q;
  assign bus.inexact        = inx_q;
  assign bus.zero           = zro_q;
  assign bus.divide_by_zero = dbz_q;
endmodule

// File: tb/tb_float_divider_double.sv
// Self-checking bench for float_divider_double: arithmetic
// reference model, per-cycle result compare, directed cases.
module tb_float_divider_double;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  float_divider_double_if bus ();

  float_divider_double dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [68:0] exp_r = '0;
  bit          exp_have = 1'b0;

  // {out, overflow, underflow, inexact, zero, divide_by_zero}
  wire [68:0] res = {bus.out, bus.overflow, bus.underflow,
                     bus.inexact, bus.zero,
                     bus.divide_by_zero};

  // Reference: a/b from long division on wide integers.
  function automatic logic [68:0] model(
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic         s;
    logic [127:0] num, den, q, r;
    logic [51:0]  mant;
    int           adj, e, ea, eb;
    logic         inx;
    s = a[63] ^ b[63];
    if (b[62:0] == 63'd0)
      return {s, 11'h7FF, 52'd0, 5'b00001};
    if (a[62:0] == 63'd0)
      return {s, 63'd0, 5'b00010};
    num = {75'd0, 1'b1, a[51:0]} << 53;
    den = {75'd0, 1'b1, b[51:0]};
    q   = num / den;
    r   = num % den;
    if (q[53]) begin
      mant = q[52:1];
      adj  = 0;
      inx  = (r != 0) || q[0];
    end else begin
      mant = q[51:0];
      adj  = 1;
      inx  = (r != 0);
    end
    ea = int'(a[62:52]);
    eb = int'(b[62:52]);
    e  = ea - eb + 1023 - adj;
    if (e >= 2047)
      return {s, 11'h7FF, 52'd0, 2'b10, inx, 2'b00};
    if (e <= 0)
      return {s, 63'd0, 2'b01, inx, 2'b10};
    return {s, e[10:0], mant, 2'b00, inx, 2'b00};
  endfunction

  task automatic chk(input string name,
                     input logic [68:0] act,
                     input logic [68:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1) begin
      if (!exp_have) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got out=%h", bus.out);
      end else begin
        chk("result", res, exp_r);
      end
    end
  end

  task automatic do_op(input logic [63:0] a,
                       input logic [63:0] b,
                       input int          lat_req,
                       input int          hold);
    int lat;
    int w;
    bit v;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 69'(bus.in_ready), 69'd1);
    @(posedge clk);
    exp_r = model(a, b);
    exp_have = 1'b1;
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = {$urandom, $urandom};
    lat = 0;
    v = 1'b0;
    while (!v && lat < 200) begin
      @(negedge clk);
      v = bus.out_valid;
      @(posedge clk);
      lat++;
    end
    chk("latency", 69'(lat), 69'(lat_req));
    if (v) begin
      repeat (hold) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 64'h4018000000000000;
        bus.b = 64'h3FF0000000000000;
        chk("hold_in_ready", 69'(bus.in_ready), 69'd0);
        chk("hold_out_valid", 69'(bus.out_valid), 69'd1);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      exp_have = 1'b0;
      #1;
      bus.out_ready = 1'b0;
      chk("release_valid", 69'(bus.out_valid), 69'd0);
      chk("release_ready", 69'(bus.in_ready), 69'd1);
      bus.in_valid = 1'b0;
    end
    exp_have = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    chk("pin_6_div_2", model(64'h4018000000000000,
        64'h4000000000000000),
        {64'h4008000000000000, 5'b00000});
    chk("pin_1_div_3", model(64'h3FF0000000000000,
        64'h4008000000000000),
        {64'h3FD5555555555555, 5'b00100});
    chk("pin_nz_div_2", model(64'h8000000000000000,
        64'h4000000000000000),
        {64'h8000000000000000, 5'b00010});
    chk("pin_1_div_0", model(64'h3FF0000000000000,
        64'h0000000000000000),
        {64'h7FF0000000000000, 5'b00001});
    chk("pin_ovf", model(64'h7FE0000000000000,
        64'h3FE0000000000000),
        {64'h7FF0000000000000, 5'b10000});
    chk("pin_unf", model(64'h0010000000000000,
        64'h4000000000000000),
        {64'h0000000000000000, 5'b01010});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_flags", res, 69'd0);
    chk("reset_in_ready", 69'(bus.in_ready), 69'd1);
    chk("reset_out_valid", 69'(bus.out_valid), 69'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(64'h4018000000000000, 64'h4000000000000000, 56, 0);
    do_op(64'h3FF0000000000000, 64'h4008000000000000, 56, 0);
    do_op(64'h8000000000000000, 64'h4000000000000000, 2, 0);
    do_op(64'h3FF0000000000000, 64'h0000000000000000, 2, 0);
    do_op(64'h7FE0000000000000, 64'h3FE0000000000000, 56, 0);
    do_op(64'h0010000000000000, 64'h4000000000000000, 56, 0);
    do_op(64'hC00C000000000000, 64'h3FF8000000000000, 56, 0);
    do_op(64'h0000000000000000, 64'h8000000000000000, 2, 0);
    do_op(64'h3FF0000000000000, 64'h4008000000000000, 56, 10);

    // Abort mid-divide; no result may appear afterwards.
    @(negedge clk);
    bus.a = 64'h4018000000000000;
    bus.b = 64'h4000000000000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    exp_r = model(bus.a, bus.b);
    exp_have = 1'b1;
    #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_have = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_in_ready", 69'(bus.in_ready), 69'd1);
    chk("midreset_out_valid", 69'(bus.out_valid), 69'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    chk("after_reset_idle", 69'(bus.in_ready), 69'd1);
    do_op(64'h4018000000000000, 64'h4000000000000000, 56, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
